// File: rtl/quad_encoder_window.sv
// Quadrature encoder front end: 2-FF sync, per-phase glitch filter, x4 decode,
// and a windowed saturating pulse accumulator published on each active-low tick.
//
// state   | meaning
// S_INIT  | first cycle after reset, capture filtered phases as the reference
// S_TRACK | decode phase changes against the previous filtered sample
module quad_encoder_window #(
  parameter int RPM_DATA   = 8,
  parameter int FILTER_LEN = 4,
  parameter int FILT_WIDTH = 3
) (
  input  logic                QUAD_ENCODER_WINDOW_CLOCK,
  input  logic                QUAD_ENCODER_WINDOW_RESET_InHigh,
  input  logic                QUAD_ENCODER_WINDOW_ENCODERA_In,
  input  logic                QUAD_ENCODER_WINDOW_ENCODERB_In,
  input  logic                QUAD_ENCODER_WINDOW_TICK_InLow,
  output logic [RPM_DATA-1:0] QUAD_ENCODER_WINDOW_COUNT_OutBus,
  output logic                QUAD_ENCODER_WINDOW_DIR_Out,
  output logic                QUAD_ENCODER_WINDOW_VALID_Out,
  output logic                QUAD_ENCODER_WINDOW_OVF_Out,
  output logic                QUAD_ENCODER_WINDOW_ERR_Out
);

  typedef enum logic {S_INIT, S_TRACK} state_t;

  localparam logic signed [RPM_DATA+1:0] POS_MAX = (RPM_DATA+2)'((2 ** RPM_DATA) - 1);
  localparam logic signed [RPM_DATA+1:0] NEG_MAX = -POS_MAX;
  localparam logic [FILT_WIDTH-1:0]      FILT_LAST = FILT_WIDTH'(FILTER_LEN - 1);

  logic                  clk;
  logic                  rst;
  logic                  tick_n;
  logic [1:0]            sync1, sync2, filt_ab, prev_ab;
  logic [FILT_WIDTH-1:0] fcnt [2];
  state_t                state;
  logic signed [RPM_DATA:0]   acc;
  logic signed [RPM_DATA+1:0] sum_w;
  logic signed [RPM_DATA:0]   acc_next;
  logic [RPM_DATA:0]          acc_abs;
  logic                  sat_now;
  logic                  ovf_acc, err_acc;
  logic [1:0]            pos_diff;
  logic signed [1:0]     delta;
  logic                  err_now;

  assign clk    = QUAD_ENCODER_WINDOW_CLOCK;
  assign rst    = QUAD_ENCODER_WINDOW_RESET_InHigh;
  assign tick_n = QUAD_ENCODER_WINDOW_TICK_InLow;

  // Synchroniser and glitch filter; bit 1 is phase A, bit 0 is phase B.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      filt_ab <= '0;
      fcnt[0] <= '0;
      fcnt[1] <= '0;
    end else begin
      sync1 <= {QUAD_ENCODER_WINDOW_ENCODERA_In, QUAD_ENCODER_WINDOW_ENCODERB_In};
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != filt_ab[i]) begin
          if (fcnt[i] == FILT_LAST) begin
            filt_ab[i] <= sync2[i];
            fcnt[i]    <= '0;
          end else begin
            fcnt[i] <= fcnt[i] + 1'b1;
          end
        end else begin
          fcnt[i] <= '0;
        end
      end
    end
  end

  // Gray code mapped to a 2-bit position; the position difference gives the step.
  always_comb begin
    pos_diff = {filt_ab[1], filt_ab[1] ^ filt_ab[0]} - {prev_ab[1], prev_ab[1] ^ prev_ab[0]};
    delta    = 2'sd0;
    err_now  = 1'b0;
    if (state == S_TRACK) begin
      if (pos_diff == 2'b10) err_now = 1'b1;
      else                   delta   = $signed(pos_diff);
    end
  end

  always_comb begin
    sum_w    = {acc[RPM_DATA], acc} + {{RPM_DATA{delta[1]}}, delta};
    sat_now  = 1'b0;
    acc_next = sum_w[RPM_DATA:0];
    if (sum_w > POS_MAX) begin
      sat_now  = 1'b1;
      acc_next = POS_MAX[RPM_DATA:0];
    end else if (sum_w < NEG_MAX) begin
      sat_now  = 1'b1;
      acc_next = NEG_MAX[RPM_DATA:0];
    end
    acc_abs = acc[RPM_DATA] ? -acc : acc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_INIT;
      prev_ab <= '0;
      acc     <= '0;
      ovf_acc <= 1'b0;
      err_acc <= 1'b0;
      QUAD_ENCODER_WINDOW_COUNT_OutBus <= '0;
      QUAD_ENCODER_WINDOW_DIR_Out      <= 1'b0;
      QUAD_ENCODER_WINDOW_VALID_Out    <= 1'b0;
      QUAD_ENCODER_WINDOW_OVF_Out      <= 1'b0;
      QUAD_ENCODER_WINDOW_ERR_Out      <= 1'b0;
    end else begin
      prev_ab <= filt_ab;
      if (state == S_INIT) state <= S_TRACK;
      QUAD_ENCODER_WINDOW_VALID_Out <= ~tick_n;
      if (!tick_n) begin
        QUAD_ENCODER_WINDOW_COUNT_OutBus <= acc_abs[RPM_DATA] ? '1 : acc_abs[RPM_DATA-1:0];
        if (acc != '0) QUAD_ENCODER_WINDOW_DIR_Out <= acc[RPM_DATA];
        QUAD_ENCODER_WINDOW_OVF_Out <= ovf_acc;
        QUAD_ENCODER_WINDOW_ERR_Out <= err_acc;
        // The tick cycle's own edge opens the new window.
        acc     <= {{(RPM_DATA-1){delta[1]}}, delta};
        ovf_acc <= 1'b0;
        err_acc <= err_now;
      end else begin
        acc <= acc_next;
        if (sat_now) ovf_acc <= 1'b1;
        if (err_now) err_acc <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_quad_encoder_window.sv
// Directed bench for quad_encoder_window: expected window results are queued at
// each tick and compared when VALID is observed.
module tb_quad_encoder_window;

  typedef struct packed {
    logic [7:0] count;
    logic       dir;
    logic       ovf;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enc_a = 1'b0;
  logic       enc_b = 1'b0;
  logic       tick_n = 1'b1;
  logic [7:0] count;
  logic       dir, valid, ovf, err;

  int   errors = 0;
  int   checks = 0;
  int   pos = 0;
  exp_t q[$];

  quad_encoder_window dut (
    .QUAD_ENCODER_WINDOW_CLOCK        (clk),
    .QUAD_ENCODER_WINDOW_RESET_InHigh (rst),
    .QUAD_ENCODER_WINDOW_ENCODERA_In  (enc_a),
    .QUAD_ENCODER_WINDOW_ENCODERB_In  (enc_b),
    .QUAD_ENCODER_WINDOW_TICK_InLow   (tick_n),
    .QUAD_ENCODER_WINDOW_COUNT_OutBus (count),
    .QUAD_ENCODER_WINDOW_DIR_Out      (dir),
    .QUAD_ENCODER_WINDOW_VALID_Out    (valid),
    .QUAD_ENCODER_WINDOW_OVF_Out      (ovf),
    .QUAD_ENCODER_WINDOW_ERR_Out      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && valid) begin
      exp_t e;
      if (q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        e = q.pop_front();
        check("count", int'(count), int'(e.count));
        check("dir",   int'(dir),   int'(e.dir));
        check("ovf",   int'(ovf),   int'(e.ovf));
        check("err",   int'(err),   int'(e.err));
      end
    end
  end

  task automatic expect_win(input int c, input bit d, input bit o, input bit e);
    exp_t x;
    x.count = 8'(c);
    x.dir   = d;
    x.ovf   = o;
    x.err   = e;
    q.push_back(x);
  endtask

  // Step the encoder n edges forward (+1) or reverse (-1), gap clocks apart.
  task automatic move(input int dirn, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      pos = (pos + dirn + 4) % 4;
      @(negedge clk);
      case (pos)
        0: begin enc_a = 1'b0; enc_b = 1'b0; end
        1: begin enc_a = 1'b0; enc_b = 1'b1; end
        2: begin enc_a = 1'b1; enc_b = 1'b1; end
        default: begin enc_a = 1'b1; enc_b = 1'b0; end
      endcase
      repeat (gap) @(posedge clk);
    end
  endtask

  task automatic pulse_a(input int width);
    @(negedge clk);
    enc_a = ~enc_a;
    repeat (width) @(negedge clk);
    enc_a = ~enc_a;
    repeat (12) @(posedge clk);
  endtask

  task automatic do_tick();
    @(negedge clk);
    tick_n = 1'b0;
    @(negedge clk);
    tick_n = 1'b1;
    check("valid_high", int'(valid), 1);
    @(negedge clk);
    check("valid_one_cycle", int'(valid), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_count"}, int'(count), 0);
    check({tag, "_dir"},   int'(dir),   0);
    check({tag, "_valid"}, int'(valid), 0);
    check({tag, "_ovf"},   int'(ovf),   0);
    check({tag, "_err"},   int'(err),   0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // 40 forward edges
    move(1, 40, 20);
    expect_win(40, 0, 0, 0);
    do_tick();
    repeat (10) @(negedge clk);
    check("hold_count", int'(count), 40);

    // 7 reverse edges, then an empty window keeps DIR
    move(-1, 7, 20);
    expect_win(7, 1, 0, 0);
    do_tick();
    repeat (20) @(posedge clk);
    expect_win(0, 1, 0, 0);
    do_tick();

    // short glitches rejected; a 4-clock pulse counts +1 then -1
    for (int i = 0; i < 5; i++) pulse_a(3);
    expect_win(0, 1, 0, 0);
    do_tick();
    pulse_a(4);
    expect_win(0, 1, 0, 0);
    do_tick();

    // saturation, then recovery
    move(1, 300, 20);
    expect_win(255, 0, 1, 0);
    do_tick();
    move(1, 5, 20);
    expect_win(5, 0, 0, 0);
    do_tick();

    // illegal 11 -> 00 transition
    @(negedge clk);
    enc_a = 1'b0;
    enc_b = 1'b0;
    pos = 0;
    repeat (20) @(posedge clk);
    expect_win(0, 0, 0, 1);
    do_tick();

    // edge decoded on the tick edge belongs to the following window
    move(1, 1, 0);
    repeat (6) @(posedge clk);
    expect_win(0, 0, 0, 0);
    do_tick();
    repeat (20) @(posedge clk);
    expect_win(1, 0, 0, 0);
    do_tick();

    // return to 00 so the post-reset reference matches the encoder
    move(-1, 1, 20);
    expect_win(1, 1, 0, 0);
    do_tick();

    // reset mid-window
    move(1, 12, 20);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_outputs_zero("midreset_async");
    repeat (3) @(negedge clk);
    check_outputs_zero("midreset_held");
    rst = 1'b0;
    repeat (5) @(posedge clk);
    move(1, 3, 20);
    expect_win(3, 0, 0, 0);
    do_tick();

    // tick held low for three cycles closes three windows
    repeat (10) @(posedge clk);
    for (int i = 0; i < 3; i++) expect_win(0, 0, 0, 0);
    @(negedge clk);
    tick_n = 1'b0;
    repeat (3) @(negedge clk);
    tick_n = 1'b1;

    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", q.size(), 0);
    check("final_valid_low", int'(valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
